// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: parametrised LCD image controller.
//   Loads an IMG_W x IMG_H image from IROM into an internal buffer. It then
//   applies window commands to the 2x2 window around a movable operating point.
//   On WRITE it dumps the buffer to IRB. The buffer is kept, so WRITE may repeat.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   cmd[3:0], cmd_valid   command code and strobe, accepted when busy=0
//   IROM_Q[DW-1:0]        IROM read data, valid the cycle after IROM_A
//   IROM_EN, IROM_A       IROM chip enable (active-low) and address
//   IRB_RW, IRB_A, IRB_D  IRB write enable (active-low), address, data
//   busy                  1 = command not accepted
//   done                  one-cycle pulse at the end of every WRITE dump
module lcd_ctrl_param #(
  parameter int DW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int AW   = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [AW-1:0] IRB_A,
  output logic [DW-1:0] IRB_D,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [AW-1:0] LAST   = AW'(N - 1);
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_INIT = XW'(IMG_W / 2);
  localparam logic [YW-1:0] Y_INIT = YW'(IMG_H / 2);

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_AVG   = 4'd5;
  localparam logic [3:0] CMD_MIRX  = 4'd6;
  localparam logic [3:0] CMD_MIRY  = 4'd7;
  localparam logic [3:0] CMD_MAX   = 4'd8;
  localparam logic [3:0] CMD_MIN   = 4'd9;
  localparam logic [3:0] CMD_ROTCW = 4'd10;
  localparam logic [3:0] CMD_ROTCC = 4'd11;

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rom_en_q, rom_en_d;
  logic [AW-1:0] rom_a_q, rom_a_d;
  logic          irb_rw_q, irb_rw_d;
  logic [AW-1:0] irb_a_q, irb_a_d;
  logic [DW-1:0] irb_d_q, irb_d_d;
  logic [DW-1:0] img_q [N];
  logic [DW-1:0] img_d [N];

  logic [AW-1:0] a_tl, a_tr, a_bl, a_br, irb_a_nxt;
  logic [DW-1:0] p_tl, p_tr, p_bl, p_br;
  logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
  logic [DW-1:0] mx, mn;
  logic [DW+1:0] sum;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cmd_d    = cmd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rom_en_d = rom_en_q;
    rom_a_d  = rom_a_q;
    irb_rw_d = irb_rw_q;
    irb_a_d  = irb_a_q;
    irb_d_d  = irb_d_q;
    img_d    = img_q;

    // Window addresses derived from BR = (X,Y); the point never leaves [1,W-1]x[1,H-1]
    a_br = AW'(int'(y_q) * IMG_W + int'(x_q));
    a_bl = a_br - AW'(1);
    a_tr = a_br - AW'(IMG_W);
    a_tl = a_tr - AW'(1);
    p_tl = img_q[a_tl];
    p_tr = img_q[a_tr];
    p_bl = img_q[a_bl];
    p_br = img_q[a_br];

    sum = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
    mx  = p_tl;
    if (p_tr > mx) mx = p_tr;
    if (p_bl > mx) mx = p_bl;
    if (p_br > mx) mx = p_br;
    mn  = p_tl;
    if (p_tr < mn) mn = p_tr;
    if (p_bl < mn) mn = p_bl;
    if (p_br < mn) mn = p_br;

    n_tl = p_tl;
    n_tr = p_tr;
    n_bl = p_bl;
    n_br = p_br;

    irb_a_nxt = irb_a_q + AW'(1);

    case (state_q)
      S_LOAD: begin
        // rom_en_q high here marks the first cycle after reset: start at address 0
        if (rom_en_q) begin
          rom_en_d = 1'b0;
          rom_a_d  = '0;
        end else begin
          img_d[rom_a_q] = IROM_Q;
          if (rom_a_q == LAST) begin
            rom_en_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            rom_a_d = rom_a_q + AW'(1);
          end
        end
      end

      S_IDLE: begin
        if (cmd_valid && !busy_q) begin
          busy_d = 1'b1;
          cmd_d  = cmd;
          if (cmd == CMD_WRITE) begin
            state_d  = S_WRITE;
            irb_rw_d = 1'b0;
            irb_a_d  = '0;
            irb_d_d  = img_q[0];
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        case (cmd_q)
          CMD_UP:    if (y_q > YW'(1)) y_d = y_q - YW'(1);
          CMD_DOWN:  if (y_q < Y_MAX)  y_d = y_q + YW'(1);
          CMD_LEFT:  if (x_q > XW'(1)) x_d = x_q - XW'(1);
          CMD_RIGHT: if (x_q < X_MAX)  x_d = x_q + XW'(1);
          CMD_AVG: begin
            n_tl = sum[DW+1:2];
            n_tr = sum[DW+1:2];
            n_bl = sum[DW+1:2];
            n_br = sum[DW+1:2];
          end
          CMD_MIRX: begin
            n_tl = p_bl;
            n_bl = p_tl;
            n_tr = p_br;
            n_br = p_tr;
          end
          CMD_MIRY: begin
            n_tl = p_tr;
            n_tr = p_tl;
            n_bl = p_br;
            n_br = p_bl;
          end
          CMD_MAX: begin
            n_tl = mx;
            n_tr = mx;
            n_bl = mx;
            n_br = mx;
          end
          CMD_MIN: begin
            n_tl = mn;
            n_tr = mn;
            n_bl = mn;
            n_br = mn;
          end
          CMD_ROTCW: begin
            n_tl = p_bl;
            n_tr = p_tl;
            n_br = p_tr;
            n_bl = p_br;
          end
          CMD_ROTCC: begin
            n_tl = p_tr;
            n_tr = p_br;
            n_br = p_bl;
            n_bl = p_tl;
          end
          default: ;
        endcase
        // Non-window commands write the old values back unchanged
        img_d[a_tl] = n_tl;
        img_d[a_tr] = n_tr;
        img_d[a_bl] = n_bl;
        img_d[a_br] = n_br;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_WRITE: begin
        if (irb_a_q == LAST) begin
          irb_rw_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          irb_a_d = irb_a_nxt;
          irb_d_d = img_q[irb_a_nxt];
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_LOAD;
      x_q      <= X_INIT;
      y_q      <= Y_INIT;
      cmd_q    <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      rom_en_q <= 1'b1;
      rom_a_q  <= '0;
      irb_rw_q <= 1'b1;
      irb_a_q  <= '0;
      irb_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rom_en_q <= rom_en_d;
      rom_a_q  <= rom_a_d;
      irb_rw_q <= irb_rw_d;
      irb_a_q  <= irb_a_d;
      irb_d_q  <= irb_d_d;
    end
  end

  // Image buffer needs no reset: it is always reloaded after reset
  always_ff @(posedge clk) begin
    img_q <= img_d;
  end

  assign IROM_EN = rom_en_q;
  assign IROM_A  = rom_a_q;
  assign IRB_RW  = irb_rw_q;
  assign IRB_A   = irb_a_q;
  assign IRB_D   = irb_d_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Testbench for lcd_ctrl_param: default 8x8/8-bit instance plus a 16x4/10-bit instance.
module tb_lcd_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (8x8, DW=8); IROM pixel = address
  logic       reset, cmd_valid, irom_en, irb_rw, busy, done;
  logic [3:0] cmd;
  logic [7:0] irom_q, irb_d;
  logic [5:0] irom_a, irb_a;

  assign irom_q = irom_en ? 8'h00 : 8'(irom_a);

  lcd_ctrl_param #(.DW(8), .IMG_W(8), .IMG_H(8)) u_dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(irom_q), .IROM_EN(irom_en), .IROM_A(irom_a),
    .IRB_RW(irb_rw), .IRB_A(irb_a), .IRB_D(irb_d),
    .busy(busy), .done(done)
  );

  // Second instance (16x4, DW=10); IROM pixel = 1023 - address
  logic       rst2, cmd_valid2, irom_en2, irb_rw2, busy2, done2;
  logic [3:0] cmd2;
  logic [9:0] irom_q2, irb_d2;
  logic [5:0] irom_a2, irb_a2;

  assign irom_q2 = irom_en2 ? 10'd0 : (10'd1023 - {4'd0, irom_a2});

  lcd_ctrl_param #(.DW(10), .IMG_W(16), .IMG_H(4)) u_dut2 (
    .clk(clk), .reset(rst2), .cmd(cmd2), .cmd_valid(cmd_valid2),
    .IROM_Q(irom_q2), .IROM_EN(irom_en2), .IROM_A(irom_a2),
    .IRB_RW(irb_rw2), .IRB_A(irb_a2), .IRB_D(irb_d2),
    .busy(busy2), .done(done2)
  );

  int irb [64];
  int irb2 [64];
  int exp_img [64];
  int done_cnt = 0;
  int done_cnt2 = 0;
  int n_checks = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (irb_rw === 1'b0)  irb[irb_a]   = int'(irb_d);
    if (irb_rw2 === 1'b0) irb2[irb_a2] = int'(irb_d2);
  end

  always @(negedge clk) begin
    if (done === 1'b1)  done_cnt++;
    if (done2 === 1'b1) done_cnt2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // All tasks start and end on a negative edge
  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) check({tag, "_idle_timeout"}, 32'(busy), 0);
  endtask

  task automatic issue(input logic [3:0] c);
    wait_idle("issue");
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input string tag);
    for (int i = 0; i < 64; i++) irb[i] = -1;
    issue(4'd0);
    wait_idle(tag);
    for (int i = 0; i < 64; i++)
      check($sformatf("%s_px%0d", tag, i), irb[i], exp_img[i]);
  endtask

  task automatic reset_load(input string tag);
    int bad = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_busy"},  32'(busy), 1);
    check({tag, "_rst_done"},  32'(done), 0);
    check({tag, "_rst_romen"}, 32'(irom_en), 1);
    check({tag, "_rst_roma"},  32'(irom_a), 0);
    check({tag, "_rst_irbrw"}, 32'(irb_rw), 1);
    check({tag, "_rst_irba"},  32'(irb_a), 0);
    check({tag, "_rst_irbd"},  32'(irb_d), 0);
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (irom_en !== 1'b0 || irom_a !== 6'(k - 1) || busy !== 1'b1) bad++;
    end
    check({tag, "_load_seq_bad"}, bad, 0);
    @(posedge clk);
    #1;
    check({tag, "_load_busy_fall"}, 32'(busy), 0);
    check({tag, "_load_romen_off"}, 32'(irom_en), 1);
    @(negedge clk);
    for (int i = 0; i < 64; i++) exp_img[i] = i;
    done_cnt = 0;
  endtask

  task automatic wait_idle2(input string tag);
    int t = 0;
    while (busy2 !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (busy2 !== 1'b0) check({tag, "_idle2_timeout"}, 32'(busy2), 0);
  endtask

  task automatic issue2(input logic [3:0] c);
    wait_idle2("issue2");
    cmd2       = c;
    cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
  endtask

  initial begin
    int hi;
    int seq_bad;
    int t;
    int bad2;
    reset      = 1'b1;
    cmd        = 4'd0;
    cmd_valid  = 1'b0;
    rst2       = 1'b1;
    cmd2       = 4'd0;
    cmd_valid2 = 1'b0;
    @(negedge clk);

    // 1: load, then plain dump
    reset_load("t1");
    do_write("t1");
    check("t1_done_cnt", done_cnt, 1);

    // 2: average of 27,28,35,36 = 126/4 = 31
    issue(4'd5);
    exp_img[27] = 31; exp_img[28] = 31; exp_img[35] = 31; exp_img[36] = 31;
    do_write("t2");
    check("t2_done_cnt", done_cnt, 2);

    // 3: move to clamp at (1,1); window 0,1,8,9 has max 9
    repeat (4) issue(4'd1);
    repeat (5) issue(4'd3);
    issue(4'd8);
    exp_img[0] = 9; exp_img[1] = 9; exp_img[8] = 9; exp_img[9] = 9;
    do_write("t3");

    // 4: fresh image; mirror-X gives 27=35,28=36,35=27,36=28; rot-CW then gives
    //    TL=BL(27), TR=TL(35), BR=TR(36), BL=BR(28)
    reset_load("t4");
    issue(4'd6);
    issue(4'd10);
    exp_img[27] = 27; exp_img[28] = 35; exp_img[35] = 28; exp_img[36] = 36;
    do_write("t4a");
    issue(4'd11);
    exp_img[27] = 35; exp_img[28] = 36; exp_img[35] = 27; exp_img[36] = 28;
    do_write("t4b");
    check("t4_done_cnt", done_cnt, 2);

    // 5: cmd_valid held with reserved cmd 13: accept every other cycle, image unchanged
    wait_idle("t5");
    cmd       = 4'd13;
    cmd_valid = 1'b1;
    hi        = 0;
    seq_bad   = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy === 1'b1) hi++;
      if (busy !== 1'(k % 2)) seq_bad++;
    end
    cmd_valid = 1'b0;
    check("t5_busy_high_cycles", hi, 10);
    check("t5_busy_pattern_bad", seq_bad, 0);
    do_write("t5");
    check("t5_done_cnt", done_cnt, 3);

    // 6: reset in the middle of a dump
    issue(4'd0);
    t = 0;
    while (irb_a !== 6'd20 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t6_reach_a20", 32'(irb_a), 20);
    check("t6_rw_active", 32'(irb_rw), 0);
    reset = 1'b1;
    #1;
    check("t6_async_rw",   32'(irb_rw), 1);
    check("t6_async_irba", 32'(irb_a), 0);
    check("t6_async_busy", 32'(busy), 1);
    @(negedge clk);
    reset_load("t6");
    do_write("t6");
    check("t6_done_cnt", done_cnt, 1);

    // 16x4, DW=10 instance: point (8,2) -> window 23,24,39,40
    check("p2_rst_busy",  32'(busy2), 1);
    check("p2_rst_romen", 32'(irom_en2), 1);
    check("p2_rst_irbrw", 32'(irb_rw2), 1);
    rst2 = 1'b0;
    bad2 = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (irom_en2 !== 1'b0 || irom_a2 !== 6'(k - 1) || busy2 !== 1'b1) bad2++;
    end
    check("p2_load_seq_bad", bad2, 0);
    @(posedge clk);
    #1;
    check("p2_load_busy_fall", 32'(busy2), 0);
    @(negedge clk);
    // pixels 1000+999+984+983 = 3966 -> floor(3966/4) = 991
    issue2(4'd5);
    for (int i = 0; i < 64; i++) irb2[i] = -1;
    issue2(4'd0);
    wait_idle2("p2_write");
    for (int i = 0; i < 64; i++) begin
      int e;
      e = 1023 - i;
      if (i == 23 || i == 24 || i == 39 || i == 40) e = 991;
      check($sformatf("p2_px%0d", i), irb2[i], e);
    end
    check("p2_done_cnt", done_cnt2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
